mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle MIPS control FSM: the sequential successor to the single-cycle opcode decoder. Sequences each instruction (lw, sw, R-type, addi, beq, bne, j) through fetch/decode/execute/memory/writeback states, drives all datapath enables and mux selects, and waits on a memory ready handshake. It traps illegal opcodes and memory timeouts, and counts retired instructions. Sits between the instruction register/ALU flags and the shared-memory multicycle datapath.

## Interface
- TIMEOUT, 16: max wait cycles for mem_ready in any memory state; 0 disables timeout.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode from the instruction register (valid from DECODE onward).
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC.
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- alu_op  out  2  00 add, 01 subtract, 10 use funct field.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data register, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse on the final cycle of each retired instruction.
- retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.
- illegal, fault  out  1 each  sticky trap causes.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE 6, ALUWB 7, BRANCH 8, ADDI 9, ADDIWB 10, JUMP 11, TRAP 12.
- Outputs not listed for a state are 0.
- FETCH
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready (Mealy).
  - Exit to DECODE when mem_ready=1; otherwise hold.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) and 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> RTYPE.
    - 001000 (addi) -> ADDI.
    - 000100 (beq) and 000101 (bne) -> BRANCH.
    - 000010 (j) -> JUMP.
    - Any other opcode -> TRAP, with illegal set.
- MEMADR
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD
  - Outputs: mem_read=1, iord=1.
  - Exit to MEMWB on mem_ready; otherwise hold.
- MEMWB
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1.
  - Instruction retires here. Next state FETCH.
- MEMWR
  - Outputs: mem_write=1, iord=1.
  - Instruction retires on the mem_ready cycle. Exit to FETCH.
- RTYPE
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state ALUWB.
- ALUWB
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Instruction retires here. Next state FETCH.
- ADDI
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state ADDIWB.
- ADDIWB
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Instruction retires here. Next state FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - Instruction retires here. Next state FETCH.
- JUMP
  - Outputs: pc_source=10, pc_write=1.
  - Instruction retires here. Next state FETCH.
- TRAP
  - Terminal until rst. All strobes are 0.
  - illegal and fault hold their values.
- Wait counter
  - Cleared on entry to FETCH, MEMRD and MEMWR, and on every mem_ready.
  - Increments each cycle those states wait with mem_ready=0.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready still 0: next state TRAP, fault set. No IR, PC or register write occurs.
  - mem_ready on the same cycle the counter reaches TIMEOUT wins: normal exit, no fault.
- instr_done and retired
  - instr_done=1 exactly on the retiring cycle.
  - retired increments on the next edge.
- Opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Timing
- Reset (rst high at an edge):
  - state=FETCH, retired=0, illegal=0, fault=0, wait counter=0.
  - Outputs then follow FETCH decoding. mem_read=1 starting the first cycle after reset.
  - Reset overrides everything, including mid-instruction and TRAP.
- Latency with mem_ready always 1, in cycles FETCH to FETCH:
  - lw 5.
  - sw, R-type, addi 4.
  - beq, bne, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Memory strobes stay asserted and constant while waiting.
- mem_ready is ignored in all other states.

## Test plan
- Reset: assert rst 2 cycles during MEMRD -> state=0, retired=0, mem_read=1, illegal=fault=0.
- lw, mem_ready=1:
  - State sequence is 0,1,2,3,4,0.
  - reg_write=1 with mem_to_reg=1 and reg_dst=0 in state 4 only.
  - instr_done pulses once; retired becomes 1.
- beq and bne:
  - beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH.
  - beq with zero=0 -> pc_write=0.
  - bne with zero=0 -> pc_write=1.
  - All three take 3 cycles.
- Wait states: sw with mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles; instruction takes 7 cycles; retired increments once.
- Timeout: TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles.
  - fault=1, ir_write and pc_write never asserted.
  - Traps hold until rst.
  - Repeat with mem_ready=1 on the 4th wait cycle -> no fault.
- Illegal opcode and counter wrap:
  - Opcode 111111 -> DECODE then TRAP, illegal=1, no reg_write.
  - CNT_W=2: 5 j instructions -> retired=1.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, traps illegal opcodes and memory timeouts.
module mc_control_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal,
    output logic             fault,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTYPE  = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_ADDI   = 4'd9,  S_ADDIWB = 4'd10, S_JUMP  = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_L = WAIT_W'(TIMEOUT);
    localparam logic            TO_EN     = (TIMEOUT != 0);

    state_t              state_r, state_next_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_next_s;
    logic [CNT_W-1:0]    retired_r;
    logic                illegal_r, fault_r, is_bne_r;
    logic                set_illegal_s, set_fault_s, waiting_s, timeout_s;

    // The cycle being decided is the TIMEOUT-th consecutive wait cycle.
    assign timeout_s       = TO_EN && ((wait_cnt_r + WAIT_W'(1'b1)) == TIMEOUT_L);
    assign wait_cnt_next_s = waiting_s ? (wait_cnt_r + WAIT_W'(1'b1)) : WAIT_W'(1'b0);

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s  = state_r;
        set_illegal_s = 1'b0;
        set_fault_s   = 1'b0;
        waiting_s     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next_s = S_DECODE;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                    set_fault_s  = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   state_next_s = S_MEMADR;
                    OP_RTYPE:       state_next_s = S_RTYPE;
                    OP_ADDI:        state_next_s = S_ADDI;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_J:           state_next_s = S_JUMP;
                    default: begin
                        state_next_s  = S_TRAP;
                        set_illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_next_s = S_MEMWB;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                    set_fault_s  = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                instr_done   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    state_next_s = S_FETCH;
                end else if (timeout_s) begin
                    state_next_s = S_TRAP;
                    set_fault_s  = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            S_RTYPE: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                state_next_s = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                instr_done   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_ADDI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                state_next_s = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b01;
                pc_source    = 2'b01;
                pc_write     = is_bne_r ? ~zero : zero;
                instr_done   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_JUMP: begin
                pc_source    = 2'b10;
                pc_write     = 1'b1;
                instr_done   = 1'b1;
                state_next_s = S_FETCH;
            end
            S_TRAP: begin
                state_next_s = S_TRAP;
            end
            default: begin
                // Unused encodings are treated as corruption and trapped.
                state_next_s = S_TRAP;
                set_fault_s  = 1'b1;
            end
        endcase
    end

    // State, wait counter, retire counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= WAIT_W'(1'b0);
            retired_r  <= CNT_W'(1'b0);
            illegal_r  <= 1'b0;
            fault_r    <= 1'b0;
            is_bne_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            illegal_r  <= illegal_r | set_illegal_s;
            fault_r    <= fault_r | set_fault_s;
            if (instr_done) begin
                retired_r <= retired_r + CNT_W'(1'b1);
            end
            // Branch flavour is captured in DECODE so BRANCH ignores later opcode changes.
            if (state_r == S_DECODE) begin
                is_bne_r <= (opcode == OP_BNE);
            end
        end
    end

    assign retired = retired_r;
    assign illegal = illegal_r;
    assign fault   = fault_r;
    assign state   = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: each cycle's expected state/controls are
// queued when inputs are driven and compared on the following falling edge.
module tb_mc_control_unit;

    localparam int CNT_W = 2;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           AD = 6'b001000, BQ = 6'b000100, BN = 6'b000101,
                           JJ = 6'b000010, XX = 6'b111111;

    logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'b000000;
    logic iord, mem_read, mem_write, ir_write, pc_write, alu_src_a;
    logic reg_dst, mem_to_reg, reg_write, instr_done, illegal, fault;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [CNT_W-1:0] retired;
    logic [3:0] state;

    logic [23:0] val_q[$];
    string       tag_q[$];
    int          compared = 0, mismatched = 0;
    logic [1:0]  exp_ret = 2'd0;
    logic        exp_ill = 1'b0, exp_flt = 1'b0, cur_bne = 1'b0;

    mc_control_unit #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
        .retired(retired), .illegal(illegal), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // {iord, mem_read, mem_write, ir_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write}
    function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                             input logic z, input logic bne);
        logic io, mr, mw, irw, pcw, sa, rd, m2r, rw;
        logic [1:0] pcs, sb, aop;
        {io, mr, mw, irw, pcw, sa, rd, m2r, rw} = 9'd0;
        {pcs, sb, aop} = 6'd0;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin sa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; aop = 2'b01; pcs = 2'b01; pcw = bne ? ~z : z; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {io, mr, mw, irw, pcw, pcs, sa, sb, aop, rd, m2r, rw};
    endfunction

    function automatic logic exp_done(input logic [3:0] st, input logic rdy);
        return (st == 4'd4) || (st == 4'd7) || (st == 4'd8) || (st == 4'd10) ||
               (st == 4'd11) || ((st == 4'd5) && rdy);
    endfunction

    // Called at posedge+1: drive this cycle's inputs and queue the expectation.
    task automatic step(input logic rdy, input logic [5:0] op, input logic z,
                        input logic [3:0] st, input string tag);
        logic d;
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        d = exp_done(st, rdy);
        val_q.push_back({st, exp_ctrl(st, rdy, z, cur_bne), d, exp_ret, exp_ill, exp_flt});
        tag_q.push_back(tag);
        if (d) exp_ret = exp_ret + 2'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_ret = 2'd0;
        exp_ill = 1'b0;
        exp_flt = 1'b0;
    endtask

    task automatic instr(input logic [5:0] op, input logic z, input logic [3:0] ex,
                         input string tag);
        step(1'b1, op, z, 4'd0, tag);
        step(1'b1, op, z, 4'd1, tag);
        step(1'b1, op, z, ex, tag);
    endtask

    // Scoreboard: pop one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        if (val_q.size() > 0) begin
            logic [23:0] e, o;
            string t;
            e = val_q.pop_front();
            t = tag_q.pop_front();
            o = {state, iord, mem_read, mem_write, ir_write, pc_write, pc_source, alu_src_a,
                 alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done, retired,
                 illegal, fault};
            compared++;
            assert (o === e) else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h (state %0d vs %0d)",
                       t, o, e, o[23:20], e[23:20]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset mid-MEMRD
        instr(LW, 1'b0, 4'd2, "lw_pre_rst");
        step(1'b0, LW, 1'b0, 4'd3, "memrd_wait");
        do_reset();
        compared++;
        if (state !== 4'd0 || mem_read !== 1'b1 || retired !== 2'd0) begin
            mismatched++;
            $error("FAIL rst_direct: state %0d mem_read %b retired %0d", state, mem_read, retired);
        end
        compared++;
        if (illegal !== 1'b0 || fault !== 1'b0) begin
            mismatched++;
            $error("FAIL rst_flags: illegal %b fault %b", illegal, fault);
        end
        step(1'b1, LW, 1'b0, 4'd0, "post_rst_fetch");
        do_reset();
        // lw; opcode garbage in MEMRD/MEMWB must be ignored
        instr(LW, 1'b0, 4'd2, "lw");
        step(1'b1, XX, 1'b0, 4'd3, "lw_memrd");
        step(1'b1, XX, 1'b0, 4'd4, "lw_memwb");
        // R-type and addi
        instr(RT, 1'b0, 4'd6, "rtype");
        step(1'b1, RT, 1'b0, 4'd7, "rtype_wb");
        instr(AD, 1'b0, 4'd9, "addi");
        step(1'b1, AD, 1'b0, 4'd10, "addi_wb");
        // Branches
        cur_bne = 1'b0;
        instr(BQ, 1'b1, 4'd8, "beq_taken");
        instr(BQ, 1'b0, 4'd8, "beq_not");
        cur_bne = 1'b1;
        instr(BN, 1'b0, 4'd8, "bne_taken");
        instr(BN, 1'b1, 4'd8, "bne_not");
        // sw with three wait cycles
        instr(SW, 1'b0, 4'd2, "sw");
        step(1'b0, SW, 1'b0, 4'd5, "sw_wait1");
        step(1'b0, SW, 1'b0, 4'd5, "sw_wait2");
        step(1'b0, SW, 1'b0, 4'd5, "sw_wait3");
        step(1'b1, SW, 1'b0, 4'd5, "sw_done");
        step(1'b1, JJ, 1'b0, 4'd0, "sw_after");
        // Fetch timeout
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, JJ, 1'b0, 4'd0, "to_wait");
        exp_flt = 1'b1;
        step(1'b1, JJ, 1'b0, 4'd12, "to_trap");
        step(1'b1, LW, 1'b0, 4'd12, "to_trap_hold");
        compared++;
        if (fault !== 1'b1 || state !== 4'd12) begin
            mismatched++;
            $error("FAIL to_direct: fault %b state %0d", fault, state);
        end
        // mem_ready on the limit cycle wins
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, JJ, 1'b0, 4'd0, "lim_wait");
        step(1'b1, JJ, 1'b0, 4'd0, "lim_ready");
        step(1'b1, JJ, 1'b0, 4'd1, "lim_decode");
        step(1'b1, JJ, 1'b0, 4'd11, "lim_jump");
        step(1'b1, JJ, 1'b0, 4'd0, "lim_after");
        compared++;
        if (fault !== 1'b0) begin
            mismatched++;
            $error("FAIL lim_direct: fault %b", fault);
        end
        // Illegal opcode
        do_reset();
        step(1'b1, XX, 1'b0, 4'd0, "ill_fetch");
        step(1'b1, XX, 1'b0, 4'd1, "ill_decode");
        exp_ill = 1'b1;
        step(1'b1, XX, 1'b0, 4'd12, "ill_trap");
        step(1'b1, LW, 1'b0, 4'd12, "ill_hold");
        compared++;
        if (illegal !== 1'b1 || reg_write !== 1'b0) begin
            mismatched++;
            $error("FAIL ill_direct: illegal %b reg_write %b", illegal, reg_write);
        end
        // Counter wrap: five jumps with a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) instr(JJ, 1'b0, 4'd11, "wrap_j");
        step(1'b1, JJ, 1'b0, 4'd0, "wrap_final");
        @(negedge clk);
        #1;
        compared++;
        if (retired !== 2'd1) begin
            mismatched++;
            $error("FAIL wrap_direct: retired %0d expected 1", retired);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        if (mismatched == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule
